// File: rtl/switch_pkg.sv
// Shared switch types: descriptor layout, scheduler states and WRR helpers.
package switch_pkg;

  localparam int ADDR_LENTH = 12;
  localparam int BLK_NUM_W  = 4;
  localparam int NUM_PRIO   = 4;
  localparam int PRIO_W     = 2;
  localparam int WEIGHT_W   = 4;
  localparam int DROP_CNT_W = 16;

  typedef struct packed {
    logic                  drop;
    logic [BLK_NUM_W-1:0]  blocknum;
    logic [ADDR_LENTH-1:0] addr;
  } desc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SERVE
  } wrr_state_e;

  // A zero weight would starve the queue forever, so it is promoted to one.
  function automatic logic [WEIGHT_W-1:0] eff_weight(input logic [WEIGHT_W-1:0] w);
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

endpackage

// File: rtl/pkt_wrr_sched_if.sv
// Enqueue (from switch fabric) and descriptor-issue (to packet-read) channels.
interface pkt_wrr_sched_if;

  logic [switch_pkg::ADDR_LENTH-1:0] iEnqAddr;
  logic [switch_pkg::BLK_NUM_W-1:0]  iEnqBlockNum;
  logic [switch_pkg::PRIO_W-1:0]     iEnqPrio;
  logic                              iEnqVld;
  logic                              oEnqRdy;

  logic [switch_pkg::ADDR_LENTH-1:0] oPktFirAddr;
  logic [switch_pkg::BLK_NUM_W-1:0]  oPktBlockNum;
  logic                              oPktDrop;
  logic                              oPktFirAddrVld;
  logic                              iPktFirAddrRdy;

  modport master (
    output iEnqAddr, iEnqBlockNum, iEnqPrio, iEnqVld, iPktFirAddrRdy,
    input  oEnqRdy, oPktFirAddr, oPktBlockNum, oPktDrop, oPktFirAddrVld
  );

  modport slave (
    input  iEnqAddr, iEnqBlockNum, iEnqPrio, iEnqVld, iPktFirAddrRdy,
    output oEnqRdy, oPktFirAddr, oPktBlockNum, oPktDrop, oPktFirAddrVld
  );

endinterface

// File: rtl/desc_fifo.sv
// Synchronous descriptor FIFO, depth 2**DEPTH_LOG2; never overwrites when full.
module desc_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  desc_t                 din_i,
  input  logic                  pop_i,
  output desc_t                 head_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  desc_t                 mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is deliberately not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din_i;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pkt_wrr_sched.sv
// Per-egress-port descriptor scheduler: four priority FIFOs, congestion drop marking,
// weighted round robin selection and a single-entry output register towards packet-read.
module pkt_wrr_sched
  import switch_pkg::*;
#(
  parameter int QDEPTH_LOG2 = 3,
  parameter int DROP_THRESH = 6
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  pkt_wrr_sched_if.slave        bus,
  input  logic [WEIGHT_W-1:0]   iWeight0,
  input  logic [WEIGHT_W-1:0]   iWeight1,
  input  logic [WEIGHT_W-1:0]   iWeight2,
  input  logic [WEIGHT_W-1:0]   iWeight3,
  output logic [NUM_PRIO-1:0]   oQueueEmpty,
  output logic [DROP_CNT_W-1:0] oDropCnt
);

  localparam int CNT_W = QDEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] DROP_LVL = CNT_W'(DROP_THRESH);

  desc_t                fifo_head [NUM_PRIO];
  logic [CNT_W-1:0]     fifo_cnt  [NUM_PRIO];
  logic [NUM_PRIO-1:0]  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WEIGHT_W-1:0]  weight    [NUM_PRIO];

  logic                 enq_fire, enq_drop;
  desc_t                enq_desc;

  wrr_state_e           state_q, state_d;
  logic [PRIO_W-1:0]    cur_q, cur_d, sel;
  logic [WEIGHT_W-1:0]  credit_q, credit_d, credit_base;
  logic                 sel_vld, fresh, serve_ok, load;

  desc_t                out_q;
  logic                 out_vld_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  assign weight[0] = iWeight0;
  assign weight[1] = iWeight1;
  assign weight[2] = iWeight2;
  assign weight[3] = iWeight3;

  // Enqueue side: drop marking looks at occupancy before this cycle's push/pop.
  assign bus.oEnqRdy = !fifo_full[bus.iEnqPrio];
  assign enq_fire    = bus.iEnqVld && bus.oEnqRdy;
  assign enq_drop    = (fifo_cnt[bus.iEnqPrio] >= DROP_LVL);
  assign enq_desc    = '{drop: enq_drop, blocknum: bus.iEnqBlockNum, addr: bus.iEnqAddr};

  always_comb begin
    fifo_push = '0;
    fifo_push[bus.iEnqPrio] = enq_fire;
  end

  for (genvar g = 0; g < NUM_PRIO; g++) begin : g_queue
    desc_fifo #(
      .DEPTH_LOG2 (QDEPTH_LOG2)
    ) u_fifo (
      .clk     (iClk),
      .rst_n   (iRst_n),
      .push_i  (fifo_push[g]),
      .din_i   (enq_desc),
      .pop_i   (fifo_pop[g]),
      .head_o  (fifo_head[g]),
      .count_o (fifo_cnt[g]),
      .full_o  (fifo_full[g]),
      .empty_o (fifo_empty[g])
    );
  end

  // The SELECT scan is resolved combinationally so a selection can pop in the same cycle,
  // which keeps idle-to-valid latency at two cycles and allows back-to-back issue.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    sel_vld  = 1'b0;
    sel      = cur_q;
    fresh    = 1'b0;
    state_d  = state_q;
    cur_d    = cur_q;
    credit_d = credit_q;
    fifo_pop = '0;

    serve_ok = (state_q == ST_SERVE) && (credit_q != '0) && !fifo_empty[cur_q];

    if (serve_ok) begin
      sel_vld = 1'b1;
    end else begin
      // Scan cur+1, cur+2, ... with cur itself last so a lone queue is re-selected.
      for (int i = 1; i <= NUM_PRIO; i++) begin
        if (!sel_vld && !fifo_empty[cur_q + PRIO_W'(i)]) begin
          sel_vld = 1'b1;
          fresh   = 1'b1;
          sel     = cur_q + PRIO_W'(i);
        end
      end
    end

    credit_base    = fresh ? eff_weight(weight[sel]) : credit_q;
    load           = sel_vld && (!out_vld_q || bus.iPktFirAddrRdy);
    fifo_pop[sel]  = load;

    if (load) begin
      cur_d    = sel;
      credit_d = credit_base - 1'b1;
      state_d  = (credit_d == '0) ? ST_SELECT : ST_SERVE;
    end else if (fresh) begin
      // Stalled output: commit the choice now so weights are sampled at selection time.
      cur_d    = sel;
      credit_d = credit_base;
      state_d  = ST_SERVE;
    end else if (!sel_vld) begin
      state_d  = ST_IDLE;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      credit_q <= credit_d;
    end
  end

  // Output register holds steady while valid and not ready; reloads on the firing cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (load) begin
      out_q     <= fifo_head[sel];
      out_vld_q <= 1'b1;
    end else if (bus.iPktFirAddrRdy) begin
      out_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      drop_cnt_q <= '0;
    end else if (enq_fire && enq_drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign bus.oPktFirAddr    = out_q.addr;
  assign bus.oPktBlockNum   = out_q.blocknum;
  assign bus.oPktDrop       = out_q.drop;
  assign bus.oPktFirAddrVld = out_vld_q;
  assign oQueueEmpty        = fifo_empty;
  assign oDropCnt           = drop_cnt_q;

endmodule
